// File: rtl/riscv_pkg.sv
// Shared integer-register constants for the RISC-V core: default data width and ABI register indices.
// Pure constants and one helper; no logic, no latency, no backpressure.
package riscv_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam int REG_ZERO = 0;
  localparam int REG_RA   = 1;
  localparam int REG_SP   = 2;

  // True when idx names the hardwired-zero register and that feature is enabled.
  function automatic logic is_zero_reg(input int unsigned idx, input int zero_reg);
    return (zero_reg != 0) && (idx == REG_ZERO);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits tracking in-flight producers: flush > writeback clear < issue set; rbusy is combinational.
// busy_vec updates one edge after issue/write; rbusy has zero latency; no backpressure.
module regfile_scoreboard
  import riscv_pkg::*;
#(
  parameter int NREGS    = 32,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int AW       = $clog2(NREGS)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic                issue_valid,
  input  logic [AW-1:0]       issue_rd,
  input  logic                flush,
  input  logic [NREAD*AW-1:0] raddr,
  output logic [NREAD-1:0]    rbusy,
  output logic [NREGS-1:0]    busy_vec
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (we)          busy_d[waddr]    = 1'b0;
      if (issue_valid) busy_d[issue_rd] = 1'b1;
    end
    if (ZERO_REG != 0) busy_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) busy_q <= '0;
    else          busy_q <= busy_d;
  end

  assign busy_vec = busy_q;

  // A write landing this cycle is forwarded to the reader, so it no longer stalls on it.
  for (genvar k = 0; k < NREAD; k++) begin : g_rbusy
    logic [AW-1:0] port_addr;
    assign port_addr = raddr[k*AW +: AW];
    assign rbusy[k]  = busy_q[port_addr] & ~((BYPASS != 0) && we && (waddr == port_addr));
  end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised integer register file with N combinational read ports, x0, write bypass and busy scoreboard.
// Reads are zero-latency, writes land on the next edge; no backpressure (decode stalls on rbusy).
module regfile_sb
  import riscv_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int NREGS    = 32,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int AW       = $clog2(NREGS)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [XLEN-1:0]       wdata,
  input  logic [NREAD*AW-1:0]   raddr,
  output logic [NREAD*XLEN-1:0] rdata,
  output logic [NREAD-1:0]      rbusy,
  input  logic                  issue_valid,
  input  logic [AW-1:0]         issue_rd,
  input  logic                  flush,
  output logic [NREGS-1:0]      busy_vec
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  always_comb begin
    regs_d = regs_q;
    if (we && !is_zero_reg(32'(waddr), ZERO_REG)) regs_d[waddr] = wdata;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Bypass is suppressed while in reset so every port reads zero.
  for (genvar k = 0; k < NREAD; k++) begin : g_read
    logic [AW-1:0]   port_addr;
    logic [XLEN-1:0] port_dat;
    assign port_addr = raddr[k*AW +: AW];

    always_comb begin
      port_dat = regs_q[port_addr];
      if ((BYPASS != 0) && reset_n && we && (waddr == port_addr)) port_dat = wdata;
      if (is_zero_reg(32'(port_addr), ZERO_REG)) port_dat = '0;
    end

    assign rdata[k*XLEN +: XLEN] = port_dat;
  end

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .NREAD    (NREAD),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS),
    .AW       (AW)
  ) u_scoreboard (
    .clock       (clock),
    .reset_n     (reset_n),
    .we          (we),
    .waddr       (waddr),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .flush       (flush),
    .raddr       (raddr),
    .rbusy       (rbusy),
    .busy_vec    (busy_vec)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: bypassing and non-bypassing instances share stimulus; a scoreboard queue
// of expected outputs is drained by a negedge monitor.
module tb_regfile_sb;
  import riscv_pkg::*;

  localparam int XL  = 32;
  localparam int NR  = 16;
  localparam int NP  = 4;
  localparam int AWT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n;
  logic              we;
  logic [AWT-1:0]    waddr;
  logic [XL-1:0]     wdata;
  logic [NP*AWT-1:0] raddr;
  logic              issue_valid;
  logic [AWT-1:0]    issue_rd;
  logic              flush;

  logic [NP*XL-1:0]  rdata_b, rdata_n;
  logic [NP-1:0]     rbusy_b, rbusy_n;
  logic [NR-1:0]     busy_vec_b, busy_vec_n;

  regfile_sb #(.XLEN(XL), .NREGS(NR), .NREAD(NP), .ZERO_REG(1), .BYPASS(1)) dut_byp (
    .clock(clk), .reset_n(reset_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b), .issue_valid(issue_valid),
    .issue_rd(issue_rd), .flush(flush), .busy_vec(busy_vec_b));

  regfile_sb #(.XLEN(XL), .NREGS(NR), .NREAD(NP), .ZERO_REG(1), .BYPASS(0)) dut_nobyp (
    .clock(clk), .reset_n(reset_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata_n), .rbusy(rbusy_n), .issue_valid(issue_valid),
    .issue_rd(issue_rd), .flush(flush), .busy_vec(busy_vec_n));

  typedef struct packed {
    logic [NP*XL-1:0] rd_b;
    logic [NP*XL-1:0] rd_n;
    logic [NP-1:0]    rb_b;
    logic [NP-1:0]    rb_n;
    logic [NR-1:0]    bv;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Architectural reference state.
  logic [XL-1:0] m_reg  [NR];
  bit            m_busy [NR];

  function automatic logic [XL-1:0] m_read(input int a, input bit byp);
    if (a == REG_ZERO) return '0;
    if (byp && we && int'(waddr) == a) return wdata;
    return m_reg[a];
  endfunction

  function automatic bit m_rbusy(input int a, input bit byp);
    if (byp && we && int'(waddr) == a) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic chk(input string name, input logic [NP*XL-1:0] act, input logic [NP*XL-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("rdata_byp",      rdata_b,                    mon_e.rd_b);
      chk("rdata_nobyp",    rdata_n,                    mon_e.rd_n);
      chk("rbusy_byp",      (NP*XL)'(rbusy_b),          (NP*XL)'(mon_e.rb_b));
      chk("rbusy_nobyp",    (NP*XL)'(rbusy_n),          (NP*XL)'(mon_e.rb_n));
      chk("busy_vec_byp",   (NP*XL)'(busy_vec_b),       (NP*XL)'(mon_e.bv));
      chk("busy_vec_nobyp", (NP*XL)'(busy_vec_n),       (NP*XL)'(mon_e.bv));
    end
  end

  // One clock of stimulus, entered just after a rising edge. rst pulses reset_n low
  // until the following negedge, so the next edge is an ordinary one.
  task automatic cyc(input bit rst, input bit w, input int wa, input logic [XL-1:0] wd,
                     input int r0, input int r1, input int r2, input int r3,
                     input bit iv, input int ird, input bit fl);
    exp_t e;
    int   ra [NP];
    ra[0] = r0; ra[1] = r1; ra[2] = r2; ra[3] = r3;
    reset_n     = !rst;
    we          = w;
    waddr       = AWT'(wa);
    wdata       = wd;
    issue_valid = iv;
    issue_rd    = AWT'(ird);
    flush       = fl;
    for (int k = 0; k < NP; k++) raddr[k*AWT +: AWT] = AWT'(ra[k]);

    e = '0;
    if (!rst) begin
      for (int k = 0; k < NP; k++) begin
        e.rd_b[k*XL +: XL] = m_read(ra[k], 1'b1);
        e.rd_n[k*XL +: XL] = m_read(ra[k], 1'b0);
        e.rb_b[k]          = m_rbusy(ra[k], 1'b1);
        e.rb_n[k]          = m_rbusy(ra[k], 1'b0);
      end
      for (int i = 0; i < NR; i++) e.bv[i] = m_busy[i];
    end
    exp_q.push_back(e);

    if (rst) begin
      @(negedge clk);
      #1;
      reset_n = 1'b1;
      for (int i = 0; i < NR; i++) begin
        m_reg[i]  = '0;
        m_busy[i] = 1'b0;
      end
    end

    @(posedge clk);
    if (w && wa != REG_ZERO) m_reg[wa] = wd;
    if (fl) begin
      for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
    end else begin
      if (w) m_busy[wa] = 1'b0;
      if (iv && ird != REG_ZERO) m_busy[ird] = 1'b1;
    end
    #1;
  endtask

  task automatic idle_read(input int r0, input int r1, input int r2, input int r3);
    cyc(0, 0, 0, '0, r0, r1, r2, r3, 0, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int wa, ird;
    int r [NP];
    reset_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr = '0;
    issue_valid = 1'b0; issue_rd = '0; flush = 1'b0;
    for (int i = 0; i < NR; i++) begin
      m_reg[i] = '0;
      m_busy[i] = 1'b0;
    end
    @(posedge clk);
    #1;

    // Reset state, with a bypass-eligible write present: every output must be zero.
    cyc(1, 1, 5, 32'h1234_5678, 5, 5, 5, 5, 1, 5, 0);

    // Async reset clears preloaded data and busy bit before any edge.
    cyc(0, 1, 5, 32'hDEAD_BEEF, 5, 0, 1, 2, 0, 0, 0);
    cyc(0, 0, 0, '0, 5, 5, 5, 5, 1, 5, 0);
    idle_read(5, 5, 5, 5);
    cyc(1, 0, 0, '0, 5, 5, 5, 5, 0, 0, 0);
    idle_read(5, 5, 0, 0);

    // Zero register ignores writes and issue marks.
    cyc(0, 1, REG_ZERO, 32'hFFFF_FFFF, 0, 0, 0, 0, 1, REG_ZERO, 0);
    idle_read(0, 0, 0, 0);

    // Bypass vs. no bypass on the same write.
    cyc(0, 1, 7, 32'h11, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 7, 32'h22, 7, 7, 0, 0, 0, 0, 0);
    idle_read(7, 7, 7, 0);

    // Scoreboard lifecycle on register 3, plus ABI registers.
    cyc(0, 0, 0, '0, 3, 0, 0, 0, 1, 3, 0);
    idle_read(3, 3, 0, 0);
    idle_read(3, 0, 0, 0);
    idle_read(3, REG_RA, REG_SP, 0);
    cyc(0, 1, 3, 32'h55, 3, 3, 0, 0, 0, 0, 0);
    idle_read(3, 3, 3, 3);
    cyc(0, 1, REG_RA, 32'hCAFE_0001, REG_RA, REG_SP, 0, 0, 1, REG_SP, 0);
    idle_read(REG_RA, REG_SP, 0, 0);

    // Set wins over clear on the same register.
    cyc(0, 0, 0, '0, 9, 0, 0, 0, 1, 9, 0);
    cyc(0, 1, 9, 32'h99, 9, 9, 0, 0, 1, 9, 0);
    idle_read(9, 9, 0, 0);

    // Flush dominates issue and clear, but the write still lands.
    cyc(0, 0, 0, '0, 4, 6, 8, 0, 1, 4, 0);
    cyc(0, 0, 0, '0, 4, 6, 8, 0, 1, 6, 0);
    cyc(0, 1, 4, 32'h44, 4, 6, 8, 0, 1, 8, 1);
    idle_read(4, 6, 8, 0);

    // Randomised traffic, biased toward address collisions.
    for (int n = 0; n < 3000; n++) begin
      wa  = $urandom_range(NR-1);
      for (int k = 0; k < NP; k++)
        r[k] = ($urandom_range(3) == 0) ? wa : $urandom_range(NR-1);
      ird = ($urandom_range(3) == 0) ? wa : $urandom_range(NR-1);
      cyc($urandom_range(99) == 0, $urandom_range(1) == 1, wa, $urandom,
          r[0], r[1], r[2], r[3],
          $urandom_range(99) < 40, ird, $urandom_range(99) < 5);
    end

    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries never compared, required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised integer register file for the pipelined RISC-V core, replacing the fixed 32x32, 2-read register array. Adds:
- N combinational read ports
- x0 hardwired to zero
- write-to-read bypass
- asynchronous clear
- per-register busy scoreboard, so decode can detect RAW hazards against in-flight producers

Sits between decode (reads, issue marking) and writeback (writes).

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of architectural registers (power of two, >=2)
NREAD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 reads as zero and ignores writes/issue marks
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports
AW, $clog2(NREGS), index width (derived; not overridden)

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous, active-low reset
we  in  1  writeback write enable
waddr  in  AW  writeback destination index
wdata  in  XLEN  writeback data
raddr  in  NREAD*AW  read indices, port k at [k*AW +: AW]
rdata  out  NREAD*XLEN  read data, port k at [k*XLEN +: XLEN]
rbusy  out  NREAD  port k's register has an outstanding producer
issue_valid  in  1  decode issues an instruction writing issue_rd
issue_rd  in  AW  destination index of issued instruction
flush  in  1  pipeline flush: drop all outstanding producers
busy_vec  out  NREGS  raw scoreboard state, for debug/verification

Behaviour:
Clock and reset:
- Single clock domain; reset_n is asynchronous and active-low.
- reset_n low: all NREGS registers = 0 and all busy bits = 0 immediately, independent of clock.
- Outputs during reset: rdata = 0 for every port, rbusy = 0, busy_vec = 0.
- Reset asserted mid-operation discards any pending write and issue; the first edge after deassertion behaves normally.

Write:
- On posedge clock with we=1, reg[waddr] <= wdata.
- ZERO_REG=1 and waddr=0: write ignored.

Read (combinational, zero latency):
- rdata[k] = reg[raddr[k]].
- ZERO_REG=1 and raddr[k]=0: rdata[k] = 0 regardless of bypass.
- BYPASS=1, we=1 and waddr=raddr[k] (and not the zero register): rdata[k] = wdata.
- BYPASS=0: old value until the edge.

Scoreboard, evaluated at each posedge in this priority order:
1. flush=1: all busy bits cleared; issue_valid and the write's clear are both ignored that cycle for the scoreboard. The register write itself still occurs.
2. Otherwise, we=1: busy[waddr] cleared.
3. Then, issue_valid=1: busy[issue_rd] set. Set wins over clear when issue_rd=waddr in the same cycle (new producer supersedes the retiring one).
- ZERO_REG=1: busy[0] never set and is constant 0.
- Re-issuing a register that is already busy leaves it busy. There is no producer count; the in-order pipeline guarantees the latest issue is the last writer.

rbusy:
- rbusy[k] = busy[raddr[k]] & ~(BYPASS & we & waddr==raddr[k]): a same-cycle bypassed write resolves the hazard.
- rbusy is combinational from current state; it does not include the same-cycle issue.

Widths and range:
- Index width AW exactly; NREGS is a power of two, so no out-of-range index exists.
- Multiple read ports on the same index are independent and identical.

Decomposition:
- Shared package riscv_pkg: XLEN default, register-index constant REG_ZERO=0, ABI index constants (REG_RA=1, REG_SP=2) used by benches.
- One sub-module, regfile_scoreboard: busy vector, set/clear/flush priority, and rbusy masking.
- Storage array and read muxing/bypass stay in regfile_sb.

Test Plan:
1. Async reset: preload reg 5=0xDEADBEEF, busy[5]=1; pulse reset_n low between edges -> rdata for raddr=5 is 0x00000000 and busy_vec=0 before the next edge.
2. Zero register: we=1, waddr=0, wdata=0xFFFFFFFF; issue_valid=1, issue_rd=0 -> reading 0 gives 0x00000000, busy_vec[0]=0.
3. Bypass: reg 7=0x11; same cycle we=1, waddr=7, wdata=0x22, raddr port0=7, port1=7 -> both rdata=0x22 before the edge. Repeat with BYPASS=0 -> 0x11, then 0x22 after the edge.
4. Scoreboard lifecycle: issue rd=3 at cycle 0 -> rbusy for raddr=3 is 1 from cycle 1. Write reg 3=0x55 at cycle 4 -> rbusy=0 combinationally in cycle 4 (bypass), and busy_vec[3]=0 after the edge.
5. Set/clear collision: busy[9]=1; same edge we=1, waddr=9, issue_valid=1, issue_rd=9 -> busy[9] stays 1 and reg 9 is updated.
6. Flush priority: busy[4], busy[6] set; flush=1 with issue_rd=8 and we to reg 4 -> busy_vec=0 after the edge and reg 4 is written. Also sweep NREAD=4, NREGS=16 with random traffic against a reference model.
